// File: rtl/sprite_loader_pkg.sv
// sprite_loader_pkg: shared states, stream command codes and palette entry type for the sprite loader
package sprite_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_PAL_START, S_PAL_CNT, S_PAL_R, S_PAL_G, S_PAL_B, S_IMG_SEL, S_IMG_DATA, S_DONE
  } state_t;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_PALETTE = 8'h01;
  localparam logic [7:0] CMD_IMAGE   = 8'h02;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/sprite_loader.sv
// sprite_loader: parses a byte stream of palette/image load commands and drives the sprite BRAM write ports
// Ports: pixel_clk, rst_n (async active-low); byte_in/byte_valid/byte_ready stream input;
// img_we/img_addr/img_data image RAM write; pal_we/pal_addr/pal_data palette RAM write;
// busy (not idle), done (command complete pulse), error (command rejected pulse).
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int FRAMES = 2,
  parameter int IMG_AW = $clog2(WIDTH * HEIGHT * FRAMES)
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              img_we,
  output logic [IMG_AW-1:0] img_addr,
  output logic [7:0]        img_data,
  output logic              pal_we,
  output logic [7:0]        pal_addr,
  output logic [23:0]       pal_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int PIX_W = $clog2(WIDTH * HEIGHT);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(WIDTH * HEIGHT - 1);
  localparam logic [IMG_AW-1:0] FRAME_SZ = IMG_AW'(WIDTH * HEIGHT);
  localparam logic [8:0] FRAMES_B = 9'(FRAMES);
  state_t state, next_state;
  logic acc, fsel_ok;
  logic [7:0] pal_ptr;
  logic [8:0] remaining;
  logic [PIX_W-1:0] pix;
  logic [IMG_AW-1:0] base;
  rgb_t pend;
  always_ff @(posedge pixel_clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (state == S_DONE) next_state = S_IDLE;
    else if (acc)
      case (state)
        S_IDLE:      next_state = byte_in == SYNC_BYTE ? S_CMD : S_IDLE;
        S_CMD:       next_state = byte_in == CMD_PALETTE ? S_PAL_START :
                                  byte_in == CMD_IMAGE ? S_IMG_SEL : S_IDLE;
        S_PAL_START: next_state = S_PAL_CNT;
        S_PAL_CNT:   next_state = S_PAL_R;
        S_PAL_R:     next_state = S_PAL_G;
        S_PAL_G:     next_state = S_PAL_B;
        S_PAL_B:     next_state = remaining == 9'd1 ? S_DONE : S_PAL_R;
        S_IMG_SEL:   next_state = fsel_ok ? S_IMG_DATA : S_IDLE;
        S_IMG_DATA:  next_state = pix == PIX_LAST ? S_DONE : S_IMG_DATA;
        default:     next_state = S_IDLE;
      endcase
  end
  always_comb begin
    byte_ready = state != S_DONE;
    busy       = state != S_IDLE;
    done       = state == S_DONE;
    acc        = byte_valid && byte_ready;
    fsel_ok    = {1'b0, byte_in} < FRAMES_B;
  end
  // Write strobes and error are single-cycle pulses, cleared unless re-armed below.
  always_ff @(posedge pixel_clk or negedge rst_n)
    if (!rst_n) begin
      img_we    <= 1'b0;
      img_addr  <= '0;
      img_data  <= '0;
      pal_we    <= 1'b0;
      pal_addr  <= '0;
      pal_data  <= '0;
      error     <= 1'b0;
      pal_ptr   <= '0;
      remaining <= '0;
      pix       <= '0;
      base      <= '0;
      pend      <= '0;
    end else begin
      img_we <= 1'b0;
      pal_we <= 1'b0;
      error  <= 1'b0;
      if (acc)
        case (state)
          S_CMD:       error <= byte_in != CMD_PALETTE && byte_in != CMD_IMAGE;
          S_PAL_START: pal_ptr <= byte_in;
          S_PAL_CNT:   remaining <= byte_in == 8'd0 ? 9'd256 : {1'b0, byte_in};
          S_PAL_R:     pend.r <= byte_in;
          S_PAL_G:     pend.g <= byte_in;
          S_PAL_B: begin
            pal_we    <= 1'b1;
            pal_addr  <= pal_ptr;
            pal_data  <= {pend.r, pend.g, byte_in};
            pal_ptr   <= pal_ptr + 8'd1;
            remaining <= remaining - 9'd1;
          end
          S_IMG_SEL: begin
            error <= !fsel_ok;
            base  <= IMG_AW'(byte_in) * FRAME_SZ;
            pix   <= '0;
          end
          S_IMG_DATA: begin
            img_we   <= 1'b1;
            img_addr <= base + IMG_AW'(pix);
            img_data <= byte_in;
            pix      <= pix == PIX_LAST ? pix : pix + 1'b1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: directed self-checking bench for sprite_loader at 4x4 pixels, 2 frames
module tb_sprite_loader;
  logic pixel_clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic byte_ready, img_we, pal_we, busy, done, error;
  logic [4:0] img_addr;
  logic [7:0] img_data, pal_addr;
  logic [23:0] pal_data;
  int checks = 0, errors = 0, done_n = 0, err_n = 0, both_n = 0;
  logic [31:0] pal_q[$], img_q[$], run_a[$];
  logic [7:0] pat[16];

  sprite_loader #(.WIDTH(4), .HEIGHT(4), .FRAMES(2), .IMG_AW(5)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .busy(busy), .done(done), .error(error));

  always #5 pixel_clk = ~pixel_clk;

  always @(negedge pixel_clk) begin
    if (pal_we) pal_q.push_back({pal_addr, pal_data});
    if (img_we) img_q.push_back(32'({img_addr, img_data}));
    if (done) done_n++;
    if (error) err_n++;
    if (pal_we && img_we) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      @(negedge pixel_clk);
      n++;
    end
    if (!byte_ready) chk("ready_timeout", 0, 1);
    @(posedge pixel_clk);
    #1;
    byte_valid = 1'b0;
    byte_in = 8'hA5;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic clear();
    pal_q.delete();
    img_q.delete();
    done_n = 0;
    err_n = 0;
  endtask

  task automatic image(input logic [7:0] fsel, input bit gaps);
    send(8'hA5); send(8'h02); send(fsel);
    for (int i = 0; i < 16; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send(pat[i]);
    end
    idle(3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge pixel_clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'({img_we, pal_we, done, error}), 0);
    chk("rst_pal", 32'({pal_addr, pal_data}), 0);
    chk("rst_img", 32'({img_addr, img_data}), 0);
    rst_n = 1'b1;
    idle(2);

    clear();
    send(8'h00); send(8'h37); idle(3);
    chk("noise_writes", 32'(pal_q.size() + img_q.size()), 0);
    chk("noise_err", 32'(err_n), 0);
    chk("noise_busy", 32'(busy), 0);

    clear();
    foreach (pat[i]) pat[i] = 8'(i);
    send(8'hA5); send(8'h01); send(8'h10); send(8'h02);
    send(8'hFF); send(8'h00); send(8'h00); send(8'h00); send(8'hFF); send(8'h00);
    idle(3);
    chk("pal_n", 32'(pal_q.size()), 2);
    chk("pal_w0", pal_q[0], 32'h10FF0000);
    chk("pal_w1", pal_q[1], 32'h1100FF00);
    chk("pal_done", 32'(done_n), 1);
    chk("pal_busy", 32'(busy), 0);

    clear();
    send(8'hA5); send(8'h01); send(8'hFE); send(8'h04);
    for (int i = 0; i < 12; i++) send(8'(i));
    idle(3);
    chk("wrap_n", 32'(pal_q.size()), 4);
    for (int k = 0; k < 4; k++)
      chk("wrap_w", pal_q[k], {8'(8'hFE + k), 8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)});

    clear();
    send(8'hA5); send(8'h01); send(8'h40); send(8'h00);
    for (int i = 0; i < 768; i++) send(8'(i));
    idle(3);
    chk("c256_n", 32'(pal_q.size()), 256);
    chk("c256_first", pal_q[0], 32'h40000102);
    chk("c256_last", pal_q[255], {8'h3F, 8'(765), 8'(766), 8'(767)});
    chk("c256_done", 32'(done_n), 1);

    clear();
    image(8'h01, 1'b0);
    send(8'h07); idle(3);
    chk("img_n", 32'(img_q.size()), 16);
    for (int i = 0; i < 16; i++) chk("img_w", img_q[i], 32'(((16 + i) << 8) | i));
    chk("img_done", 32'(done_n), 1);
    chk("img_busy", 32'(busy), 0);
    chk("excl", 32'(both_n), 0);

    clear();
    send(8'hA5); send(8'h07); idle(3);
    chk("badcmd_err", 32'(err_n), 1);
    chk("badcmd_busy", 32'(busy), 0);
    chk("badcmd_done", 32'(done_n), 0);

    clear();
    send(8'hA5); send(8'h02); send(8'h02); idle(3);
    chk("badsel_err", 32'(err_n), 1);
    chk("badsel_img", 32'(img_q.size()), 0);
    chk("badsel_busy", 32'(busy), 0);

    foreach (pat[i]) pat[i] = (i == 3 || i == 9) ? 8'hA5 : 8'(3 * i + 1);
    clear();
    image(8'h00, 1'b0);
    run_a = img_q;
    clear();
    image(8'h00, 1'b1);
    chk("stall_n", 32'(img_q.size()), 16);
    for (int i = 0; i < 16; i++) begin
      chk("stall_w", img_q[i], 32'((i << 8) | pat[i]));
      chk("stall_same", img_q[i], run_a[i]);
    end
    chk("stall_done", 32'(done_n), 1);

    clear();
    foreach (pat[i]) pat[i] = 8'(8'hC0 + i);
    send(8'hA5); send(8'h02); send(8'h01);
    for (int i = 0; i < 5; i++) send(pat[i]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out", 32'({img_we, img_addr, img_data}), 0);
    chk("mid_rst_ready", 32'(byte_ready), 1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear();
    image(8'h00, 1'b0);
    chk("rst_img_n", 32'(img_q.size()), 16);
    for (int i = 0; i < 16; i++) chk("rst_img_w", img_q[i], 32'((i << 8) | pat[i]));
    chk("rst_img_done", 32'(done_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
